key_debounce_array: RTL and testbench

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

---
 rtl/key_pkg.sv | 19 +
 rtl/key_debounce_array_if.sv | 21 ++
 rtl/key_channel.sv | 117 +++++++++++
 rtl/key_debounce_array.sv | 42 ++++
 tb/tb_key_debounce_array.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared types and width helpers for the key debounce / auto-repeat array.
package key_pkg;

    typedef enum logic [1:0] {
        REP_IDLE  = 2'd0,
        REP_DELAY = 2'd1,
        REP_RUN   = 2'd2
    } rep_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..max_count; never less than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/key_debounce_array_if.sv
// Key pins, repeat enables and per-key event outputs bundled for the array.
interface key_debounce_array_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] i_keys;
    logic [N_KEYS-1:0] i_repeat_en;
    logic [N_KEYS-1:0] o_level;
    logic [N_KEYS-1:0] o_press;
    logic [N_KEYS-1:0] o_release;
    logic [N_KEYS-1:0] o_step;

    modport master (
        output i_keys, i_repeat_en,
        input  o_level, o_press, o_release, o_step
    );

    modport slave (
        input  i_keys, i_repeat_en,
        output o_level, o_press, o_release, o_step
    );
endinterface

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, polarity-normalised sample register,
// debounce counter and auto-repeat FSM. All outputs are registered.
module key_channel
    import key_pkg::*;
#(
    parameter int DEB_CYCLES    = 250,
    parameter int REPEAT_DELAY  = 50000,
    parameter int REPEAT_PERIOD = 10000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_step
);
    localparam int DW = cnt_width(DEB_CYCLES);
    localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic          sync1_q, sync2_q, sample_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          step_q, step_d;
    logic          toggle;
    rep_state_t    state_q, state_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q   <= IDLE_PIN;
            sync2_q   <= IDLE_PIN;
            sample_q  <= 1'b0;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
            state_q   <= REP_IDLE;
            rep_cnt_q <= '0;
        end else begin
            sync1_q   <= i_key;
            sync2_q   <= sync1_q;
            sample_q  <= sync2_q ^ IDLE_PIN;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            step_q    <= step_d;
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // Any sample agreeing with the accepted level restarts the stability run.
    always_comb begin
        deb_cnt_d = '0;
        level_d   = level_q;
        toggle    = 1'b0;
        if (sample_q != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                toggle  = 1'b1;
                level_d = ~level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        press_d   = toggle & ~level_q;
        release_d = toggle & level_q;
    end

    // Cancellation is tested before the tick so a release never emits a step.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        step_d    = 1'b0;
        unique case (state_q)
            REP_IDLE: begin
                rep_cnt_d = '0;
                if (press_d) begin
                    step_d = 1'b1;
                    if (i_repeat_en) state_d = REP_DELAY;
                end
            end
            REP_DELAY, REP_RUN: begin
                if (release_d || !i_repeat_en) begin
                    state_d   = REP_IDLE;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == ((state_q == REP_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                    step_d    = 1'b1;
                    rep_cnt_d = '0;
                    state_d   = REP_RUN;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = REP_IDLE;
                rep_cnt_d = '0;
            end
        endcase
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_step    = step_q;

endmodule

// File: rtl/key_debounce_array.sv
// Array of independent debounced keys with per-key auto-repeat.
module key_debounce_array
    import key_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter int DEB_CYCLES    = 250,
    parameter int REPEAT_DELAY  = 50000,
    parameter int REPEAT_PERIOD = 10000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    key_debounce_array_if.slave  kb
);
    logic [N_KEYS-1:0] level_w, press_w, release_w, step_w;

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
            key_channel #(
                .DEB_CYCLES   (DEB_CYCLES),
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_PERIOD(REPEAT_PERIOD),
                .ACTIVE_LOW   (ACTIVE_LOW)
            ) u_ch (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_key      (kb.i_keys[gi]),
                .i_repeat_en(kb.i_repeat_en[gi]),
                .o_level    (level_w[gi]),
                .o_press    (press_w[gi]),
                .o_release  (release_w[gi]),
                .o_step     (step_w[gi])
            );
        end
    endgenerate

    assign kb.o_level   = level_w;
    assign kb.o_press   = press_w;
    assign kb.o_release = release_w;
    assign kb.o_step    = step_w;

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed scenarios plus randomized key traffic checked every cycle against
// a window-based reference model of debounce and auto-repeat timing.
module tb_key_debounce_array;
    localparam int N     = 4;
    localparam int DEB   = 8;
    localparam int RD    = 20;
    localparam int RP    = 5;
    localparam int MAXC  = 4000;
    localparam int NDIR  = 229;
    localparam int NRAND = 3000;

    logic clk = 1'b0;
    logic rst;

    key_debounce_array_if #(.N_KEYS(N)) kb ();

    key_debounce_array #(
        .N_KEYS       (N),
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .ACTIVE_LOW   (1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .kb   (kb)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Normalised (1 = pressed) pin value sampled at each edge.
    logic [N-1:0] pin_hist  [0:MAXC-1];
    logic [N-1:0] obs_level [0:MAXC-1];
    logic [N-1:0] obs_press [0:MAXC-1];
    logic [N-1:0] obs_rel   [0:MAXC-1];
    logic [N-1:0] obs_step  [0:MAXC-1];

    int           last_reset;
    logic [N-1:0] m_level;
    int           m_last_change [N];
    bit           m_active      [N];
    int           m_next        [N];
    logic [N-1:0] e_press, e_rel, e_step;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic pin_at(input int ch, input int x);
        if (x <= last_reset || x < 0) return 1'b0;
        return pin_hist[x][ch];
    endfunction

    // Level flips at edge t when the DEB most recent samples seen by the
    // debouncer (pins from edges t-DEB-2 .. t-3) all disagree with it and
    // none of them predates the previous flip or reset.
    task automatic model_edge(input int t);
        bit tog;
        pin_hist[t] = ~kb.i_keys;
        e_press = '0;
        e_rel   = '0;
        e_step  = '0;
        if (rst) begin
            last_reset = t;
            m_level    = '0;
            for (int ch = 0; ch < N; ch++) begin
                m_last_change[ch] = t;
                m_active[ch]      = 1'b0;
            end
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                tog = (t - DEB >= m_last_change[ch]);
                for (int k = 0; k < DEB; k++)
                    if (pin_at(ch, t - k - 3) == m_level[ch]) tog = 1'b0;
                e_press[ch] = tog && !m_level[ch];
                e_rel[ch]   = tog && m_level[ch];
                if (tog) begin
                    m_level[ch]       = ~m_level[ch];
                    m_last_change[ch] = t;
                end
                if (e_rel[ch]) m_active[ch] = 1'b0;
                else if (m_active[ch] && !kb.i_repeat_en[ch]) m_active[ch] = 1'b0;
                else if (m_active[ch] && t == m_next[ch]) begin
                    e_step[ch] = 1'b1;
                    m_next[ch] = t + RP;
                end
                if (e_press[ch]) begin
                    e_step[ch] = 1'b1;
                    if (kb.i_repeat_en[ch]) begin
                        m_active[ch] = 1'b1;
                        m_next[ch]   = t + RD;
                    end
                end
            end
        end
    endtask

    task automatic run_edge();
        @(posedge clk);
        cyc++;
        model_edge(cyc);
        #1;
        obs_level[cyc] = kb.o_level;
        obs_press[cyc] = kb.o_press;
        obs_rel[cyc]   = kb.o_release;
        obs_step[cyc]  = kb.o_step;
        check($sformatf("level@%0d", cyc),   32'(kb.o_level),   32'(m_level));
        check($sformatf("press@%0d", cyc),   32'(kb.o_press),   32'(e_press));
        check($sformatf("release@%0d", cyc), 32'(kb.o_release), 32'(e_rel));
        check($sformatf("step@%0d", cyc),    32'(kb.o_step),    32'(e_step));
    endtask

    function automatic int count_bits(input int ch, input int from, input int to, input int which);
        int c = 0;
        for (int t = from; t <= to; t++) begin
            case (which)
                0: c += int'(obs_level[t][ch]);
                1: c += int'(obs_press[t][ch]);
                2: c += int'(obs_rel[t][ch]);
                default: c += int'(obs_step[t][ch]);
            endcase
        end
        return c;
    endfunction

    int           hold_left [N];
    logic [N-1:0] pressed;
    int           e;

    initial begin
        last_reset = 0;
        m_level    = '0;
        for (int ch = 0; ch < N; ch++) begin
            m_last_change[ch] = 0;
            m_active[ch]      = 1'b0;
            m_next[ch]        = 0;
        end
        rst            = 1'b1;
        kb.i_keys      = '1;
        kb.i_repeat_en = '0;

        // Directed timeline; inputs for edge e are applied after edge e-1.
        for (int i = 0; i < NDIR; i++) begin
            e = cyc + 1;
            rst = (e <= 3) || (e == 200);
            pressed[0] = (e >= 100);
            pressed[1] = (e >= 120) && (e <= 126);
            pressed[2] = (e >= 130) && (e <= 179);
            pressed[3] = (e >= 130) && (e <= 194);
            kb.i_keys      = ~pressed;
            kb.i_repeat_en = {(e >= 150), 1'b1, 1'b0, 1'b0};
            run_edge();
        end

        check("reset_level@1", 32'(obs_level[1]), 32'd0);
        check("reset_step@1",  32'(obs_step[1]),  32'd0);
        check("k0_level@109",  32'(obs_level[109][0]), 32'd0);
        check("k0_level@110",  32'(obs_level[110][0]), 32'd1);
        check("k0_press@110",  32'(obs_press[110][0]), 32'd1);
        check("k0_step@110",   32'(obs_step[110][0]),  32'd1);
        check("k0_press@111",  32'(obs_press[111][0]), 32'd0);
        $display("[TB] key0 press: level rises at edge 110");

        check("k1_levels", 32'(count_bits(1, 100, NDIR, 0)), 32'd0);
        check("k1_presses", 32'(count_bits(1, 100, NDIR, 1)), 32'd0);
        $display("[TB] key1 7-cycle glitch: rejected");

        check("k2_step@140", 32'(obs_step[140][2]), 32'd1);
        check("k2_step@159", 32'(obs_step[159][2]), 32'd0);
        check("k2_step@160", 32'(obs_step[160][2]), 32'd1);
        check("k2_step@165", 32'(obs_step[165][2]), 32'd1);
        check("k2_step@185", 32'(obs_step[185][2]), 32'd1);
        check("k2_rel@190",  32'(obs_rel[190][2]),  32'd1);
        check("k2_step@190", 32'(obs_step[190][2]), 32'd0);
        check("k2_steps",    32'(count_bits(2, 130, NDIR, 3)), 32'd7);
        $display("[TB] key2 auto-repeat: steps 140,160..185, release at 190");

        check("k3_steps", 32'(count_bits(3, 130, NDIR, 3)), 32'd1);
        $display("[TB] key3 repeat disabled at press: single step");

        check("rst_level@200",   32'(obs_level[200]), 32'd0);
        check("rst_press@200",   32'(obs_press[200]), 32'd0);
        check("rst_release@200", 32'(obs_rel[200]),   32'd0);
        check("rst_step@200",    32'(obs_step[200]),  32'd0);
        check("k0_press@210",    32'(obs_press[210][0]), 32'd0);
        check("k0_press@211",    32'(obs_press[211][0]), 32'd1);
        $display("[TB] mid-hold reset: key0 re-pressed at edge 211");

        // Randomized phase: mix of glitch-length and long holds per key.
        for (int ch = 0; ch < N; ch++) hold_left[ch] = 0;
        for (int i = 0; i < NRAND; i++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (hold_left[ch] == 0) begin
                    pressed[ch]   = ~pressed[ch];
                    hold_left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 70))
                                                                : int'($urandom_range(1, 12));
                end
                hold_left[ch]--;
                if ($urandom_range(0, 59) == 0) kb.i_repeat_en[ch] = ~kb.i_repeat_en[ch];
            end
            kb.i_keys = ~pressed;
            rst = ($urandom_range(0, 699) == 0);
            run_edge();
        end
        $display("[TB] random traffic: %0d cycles compared", NRAND);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
